// File: rtl/convolution_processor_memz_drain.sv
// convolution_processor_memz_drain
// Result buffer behind convolution_processor. It captures the Z-memory write
// stream into an internal RAM and, on done_i, replays the samples in address
// order over a valid/ready stream.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   writeZ_i/dataZ_i/memZ_addr_i  Z write stream from the processor
//   done_i                   one-cycle end-of-convolution pulse
//   z_data_o/z_idx_o         streamed sample and its address
//   z_valid_o/z_ready_i      stream handshake
//   z_last_o                 final sample of the frame (qualified by z_valid_o)
//   ready_o                  buffer idle, a new convolution may start
//   err_o                    sticky protocol error (write/done while draining)
module convolution_processor_memz_drain #(
  parameter int DATA_Z_WIDTH    = 16,
  parameter int MEMZ_ADDR_WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       writeZ_i,
  input  logic [DATA_Z_WIDTH-1:0]    dataZ_i,
  input  logic [MEMZ_ADDR_WIDTH-1:0] memZ_addr_i,
  input  logic                       done_i,
  output logic [DATA_Z_WIDTH-1:0]    z_data_o,
  output logic [MEMZ_ADDR_WIDTH-1:0] z_idx_o,
  output logic                       z_valid_o,
  input  logic                       z_ready_i,
  output logic                       z_last_o,
  output logic                       ready_o,
  output logic                       err_o
);

  localparam int DEPTH = 1 << MEMZ_ADDR_WIDTH;
  localparam int CW    = MEMZ_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, PREFETCH, STREAM} state_t;

  state_t                     state_q, state_d;
  logic [DATA_Z_WIDTH-1:0]    mem [DEPTH];
  // Per-entry written flags: an entry reads as zero unless written since it
  // was last drained, so never-written addresses below count stream as 0.
  logic [DEPTH-1:0]           live_q;
  logic [CW-1:0]              count_q;
  logic [MEMZ_ADDR_WIDTH-1:0] idx_q;
  logic [DATA_Z_WIDTH-1:0]    dout_q;
  logic                       err_q;

  logic                       wr_en;
  logic                       rd_en;
  logic [MEMZ_ADDR_WIDTH-1:0] rd_addr;
  logic                       handshake;
  logic                       is_last;
  logic [CW-1:0]              wr_end;
  logic                       busy;

  assign busy      = (state_q == PREFETCH) || (state_q == STREAM);
  assign handshake = (state_q == STREAM) && z_ready_i;
  assign is_last   = ({1'b0, idx_q} == (count_q - CW'(1)));
  assign wr_end    = {1'b0, memZ_addr_i} + CW'(1);

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    rd_addr = idx_q + MEMZ_ADDR_WIDTH'(1);
    case (state_q)
      IDLE: begin
        wr_en = writeZ_i;
        // done_i alone in IDLE means an empty frame: nothing to emit.
        if (writeZ_i) state_d = done_i ? PREFETCH : COLLECT;
      end
      COLLECT: begin
        wr_en = writeZ_i;
        if (done_i) state_d = PREFETCH;
      end
      PREFETCH: begin
        rd_en   = 1'b1;
        rd_addr = '0;
        state_d = STREAM;
      end
      STREAM: begin
        // The registered RAM read doubles as the output register: a read is
        // only issued on handshake, so stalls hold it and back-to-back
        // handshakes still deliver one sample per cycle.
        if (handshake) begin
          if (is_last) state_d = IDLE;
          else         rd_en   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[memZ_addr_i] <= dataZ_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        live_q[memZ_addr_i] <= 1'b1;
        if (wr_end > count_q) count_q <= wr_end;
      end
      if (rd_en) begin
        dout_q          <= live_q[rd_addr] ? mem[rd_addr] : '0;
        live_q[rd_addr] <= 1'b0;
      end
      if (state_q == PREFETCH) begin
        idx_q <= '0;
      end else if (handshake) begin
        if (is_last) begin
          idx_q   <= '0;
          count_q <= '0;
        end else begin
          idx_q <= idx_q + MEMZ_ADDR_WIDTH'(1);
        end
      end
      if (busy && (writeZ_i || done_i)) err_q <= 1'b1;
    end
  end

  assign z_data_o  = dout_q;
  assign z_idx_o   = idx_q;
  assign z_valid_o = (state_q == STREAM);
  assign z_last_o  = (state_q == STREAM) && is_last;
  assign ready_o   = (state_q == IDLE);
  assign err_o     = err_q;

endmodule
